// File: rtl/rs_station_if.sv
// Bundles the issue, CDB and execution-unit sides of the reservation station.
// master drives issue/CDB/control and consumes status; slave is the station.
interface rs_station_if #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 4,
    parameter int OP_W     = 6,
    parameter int RS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RS_DEPTH) + 1;

    logic             stall_i;
    logic             flush_i;

    logic             issue_en_i;
    logic [OP_W-1:0]  issue_op_i;
    logic [TAG_W-1:0] issue_tag_i;
    logic             issue_rs1_valid_i;
    logic [XLEN-1:0]  issue_rs1_value_i;
    logic [TAG_W-1:0] issue_rs1_tag_i;
    logic             issue_rs2_valid_i;
    logic [XLEN-1:0]  issue_rs2_value_i;
    logic [TAG_W-1:0] issue_rs2_tag_i;
    logic             full_o;
    logic [CNT_W-1:0] count_o;

    logic             cdb_valid_i;
    logic [TAG_W-1:0] cdb_tag_i;
    logic [XLEN-1:0]  cdb_value_i;

    logic             ex_valid_o;
    logic             ex_ready_i;
    logic [OP_W-1:0]  ex_op_o;
    logic [XLEN-1:0]  ex_rs1_o;
    logic [XLEN-1:0]  ex_rs2_o;
    logic [TAG_W-1:0] ex_tag_o;

    modport master (
        output stall_i, flush_i,
        output issue_en_i, issue_op_i, issue_tag_i,
        output issue_rs1_valid_i, issue_rs1_value_i, issue_rs1_tag_i,
        output issue_rs2_valid_i, issue_rs2_value_i, issue_rs2_tag_i,
        input  full_o, count_o,
        output cdb_valid_i, cdb_tag_i, cdb_value_i,
        input  ex_valid_o, ex_op_o, ex_rs1_o, ex_rs2_o, ex_tag_o,
        output ex_ready_i
    );

    modport slave (
        input  stall_i, flush_i,
        input  issue_en_i, issue_op_i, issue_tag_i,
        input  issue_rs1_valid_i, issue_rs1_value_i, issue_rs1_tag_i,
        input  issue_rs2_valid_i, issue_rs2_value_i, issue_rs2_tag_i,
        output full_o, count_o,
        input  cdb_valid_i, cdb_tag_i, cdb_value_i,
        output ex_valid_o, ex_op_o, ex_rs1_o, ex_rs2_o, ex_tag_o,
        input  ex_ready_i
    );
endinterface

// File: rtl/rs_station.sv
// Tomasulo reservation station: captures operands from the CDB and dispatches the oldest ready entry.
// Optional macro RS_CDB_SELECT_BYPASS_EN lets an entry completed by the current CDB broadcast dispatch at once.
module rs_station #(
    parameter int XLEN     = 32,
    parameter int TAG_W    = 4,
    parameter int OP_W     = 6,
    parameter int RS_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    rs_station_if.slave  bus
);
    localparam int AGE_W = $clog2(RS_DEPTH);
    localparam int IDX_W = AGE_W;
    localparam int CNT_W = AGE_W + 1;

    logic [RS_DEPTH-1:0] busy;
    logic [RS_DEPTH-1:0] rs1_valid;
    logic [RS_DEPTH-1:0] rs2_valid;
    logic [OP_W-1:0]     op        [RS_DEPTH];
    logic [TAG_W-1:0]    tag       [RS_DEPTH];
    logic [XLEN-1:0]     rs1_value [RS_DEPTH];
    logic [XLEN-1:0]     rs2_value [RS_DEPTH];
    logic [TAG_W-1:0]    rs1_tag   [RS_DEPTH];
    logic [TAG_W-1:0]    rs2_tag   [RS_DEPTH];
    logic [AGE_W-1:0]    age       [RS_DEPTH];

    logic             ex_valid;
    logic [OP_W-1:0]  ex_op;
    logic [XLEN-1:0]  ex_rs1;
    logic [XLEN-1:0]  ex_rs2;
    logic [TAG_W-1:0] ex_tag;

    logic [CNT_W-1:0]    busy_count;
    logic [RS_DEPTH-1:0] rs1_hit;
    logic [RS_DEPTH-1:0] rs2_hit;
    logic [RS_DEPTH-1:0] ready;
    logic                any_ready;
    logic                any_free;
    logic [IDX_W-1:0]    sel_idx;
    logic [AGE_W-1:0]    sel_age;
    logic [IDX_W-1:0]    free_idx;
    logic [XLEN-1:0]     sel_rs1;
    logic [XLEN-1:0]     sel_rs2;
    logic                full;
    logic                do_alloc;
    logic                do_load;
    logic                iss_rs1_hit;
    logic                iss_rs2_hit;

    // Strict '>' keeps the lowest index on an age tie.
    always_comb begin
        busy_count = '0;
        rs1_hit    = '0;
        rs2_hit    = '0;
        ready      = '0;
        any_ready  = 1'b0;
        any_free   = 1'b0;
        sel_idx    = '0;
        sel_age    = '0;
        free_idx   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            busy_count = busy_count + CNT_W'(busy[i]);
            rs1_hit[i] = bus.cdb_valid_i && !rs1_valid[i] && (rs1_tag[i] == bus.cdb_tag_i);
            rs2_hit[i] = bus.cdb_valid_i && !rs2_valid[i] && (rs2_tag[i] == bus.cdb_tag_i);
`ifdef RS_CDB_SELECT_BYPASS_EN
            ready[i] = busy[i] && (rs1_valid[i] || rs1_hit[i]) && (rs2_valid[i] || rs2_hit[i]);
`else
            ready[i] = busy[i] && rs1_valid[i] && rs2_valid[i];
`endif
            if (ready[i] && (!any_ready || (age[i] > sel_age))) begin
                any_ready = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age[i];
            end
            if (!busy[i] && !any_free) begin
                any_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
`ifdef RS_CDB_SELECT_BYPASS_EN
        sel_rs1 = rs1_valid[sel_idx] ? rs1_value[sel_idx] : bus.cdb_value_i;
        sel_rs2 = rs2_valid[sel_idx] ? rs2_value[sel_idx] : bus.cdb_value_i;
`else
        sel_rs1 = rs1_value[sel_idx];
        sel_rs2 = rs2_value[sel_idx];
`endif
    end

    assign full        = (busy_count == CNT_W'(RS_DEPTH));
    assign do_alloc    = bus.issue_en_i && !full && any_free && !bus.stall_i;
    assign do_load     = any_ready && !bus.stall_i && (!ex_valid || bus.ex_ready_i);
    assign iss_rs1_hit = !bus.issue_rs1_valid_i && bus.cdb_valid_i && (bus.issue_rs1_tag_i == bus.cdb_tag_i);
    assign iss_rs2_hit = !bus.issue_rs2_valid_i && bus.cdb_valid_i && (bus.issue_rs2_tag_i == bus.cdb_tag_i);

    // Ages saturate so a long-lived entry never wraps and loses its seniority.
    always_ff @(posedge clk) begin
        if (!rst || bus.flush_i) begin
            busy      <= '0;
            rs1_valid <= '0;
            rs2_valid <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age[i] <= '0;
            end
            ex_valid <= 1'b0;
            ex_op    <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_tag   <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (busy[i]) begin
                    if (rs1_hit[i]) begin
                        rs1_valid[i] <= 1'b1;
                        rs1_value[i] <= bus.cdb_value_i;
                    end
                    if (rs2_hit[i]) begin
                        rs2_valid[i] <= 1'b1;
                        rs2_value[i] <= bus.cdb_value_i;
                    end
                    if (do_alloc && (age[i] != '1)) begin
                        age[i] <= age[i] + AGE_W'(1);
                    end
                    if (do_load && (sel_idx == IDX_W'(i))) begin
                        busy[i] <= 1'b0;
                    end
                end else if (do_alloc && (free_idx == IDX_W'(i))) begin
                    busy[i]      <= 1'b1;
                    op[i]        <= bus.issue_op_i;
                    tag[i]       <= bus.issue_tag_i;
                    age[i]       <= '0;
                    rs1_valid[i] <= bus.issue_rs1_valid_i || iss_rs1_hit;
                    rs1_value[i] <= iss_rs1_hit ? bus.cdb_value_i : bus.issue_rs1_value_i;
                    rs1_tag[i]   <= bus.issue_rs1_tag_i;
                    rs2_valid[i] <= bus.issue_rs2_valid_i || iss_rs2_hit;
                    rs2_value[i] <= iss_rs2_hit ? bus.cdb_value_i : bus.issue_rs2_value_i;
                    rs2_tag[i]   <= bus.issue_rs2_tag_i;
                end
            end

            if (do_load) begin
                ex_valid <= 1'b1;
                ex_op    <= op[sel_idx];
                ex_tag   <= tag[sel_idx];
                ex_rs1   <= sel_rs1;
                ex_rs2   <= sel_rs2;
            end else if (bus.ex_ready_i) begin
                ex_valid <= 1'b0;
            end
        end
    end

    assign bus.full_o     = full;
    assign bus.count_o    = busy_count;
    assign bus.ex_valid_o = ex_valid;
    assign bus.ex_op_o    = ex_op;
    assign bus.ex_rs1_o   = ex_rs1;
    assign bus.ex_rs2_o   = ex_rs2;
    assign bus.ex_tag_o   = ex_tag;
endmodule

// File: tb/tb_rs_station.sv
// Scoreboard bench for rs_station: stimulus pushes expected dispatches, a negedge monitor pops on handshakes.
module tb_rs_station;
    typedef struct packed {
        logic [5:0]  op;
        logic [3:0]  tag;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    logic clk;
    logic rst;
    exp_t exp_q[$];
    int   check_count;
    int   pass_count;

    rs_station_if bus ();

    rs_station dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [3:0] tag,
                                 input logic v1, input logic [31:0] val1, input logic [3:0] t1,
                                 input logic v2, input logic [31:0] val2, input logic [3:0] t2);
        bus.issue_en_i        = 1'b1;
        bus.issue_op_i        = op;
        bus.issue_tag_i       = tag;
        bus.issue_rs1_valid_i = v1;
        bus.issue_rs1_value_i = val1;
        bus.issue_rs1_tag_i   = t1;
        bus.issue_rs2_valid_i = v2;
        bus.issue_rs2_value_i = val2;
        bus.issue_rs2_tag_i   = t2;
    endtask

    task automatic stopIssue();
        bus.issue_en_i = 1'b0;
    endtask

    task automatic setCdb(input logic v, input logic [3:0] t, input logic [31:0] val);
        bus.cdb_valid_i = v;
        bus.cdb_tag_i   = t;
        bus.cdb_value_i = val;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        if (rst && !bus.flush_i && bus.ex_valid_o && bus.ex_ready_i) begin
            got = '{op: bus.ex_op_o, tag: bus.ex_tag_o, rs1: bus.ex_rs1_o, rs2: bus.ex_rs2_o};
            check_count++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL dispatch_unexpected: got tag=%0d op=0x%0h, required no dispatch",
                         got.tag, got.op);
            end else begin
                e = exp_q.pop_front();
                if (got === e) begin
                    pass_count++;
                end else begin
                    $display("[TB] FAIL dispatch: got op=0x%0h tag=%0d rs1=0x%0h rs2=0x%0h, required op=0x%0h tag=%0d rs1=0x%0h rs2=0x%0h",
                             got.op, got.tag, got.rs1, got.rs2, e.op, e.tag, e.rs1, e.rs2);
                end
            end
        end
    end

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst            = 1'b0;
        bus.stall_i    = 1'b0;
        bus.flush_i    = 1'b0;
        bus.ex_ready_i = 1'b0;
        setCdb(1'b0, 4'd0, 32'd0);
        applyStimulus(6'h03, 4'd5, 1'b1, 32'd10, 4'd0, 1'b1, 32'd20, 4'd0);

        // Reset with issue_en held high must keep the station empty.
        tick();
        tick();
        checkOutput("reset_ex_valid", 64'(bus.ex_valid_o), 64'd0);
        checkOutput("reset_count", 64'(bus.count_o), 64'd0);
        checkOutput("reset_full", 64'(bus.full_o), 64'd0);
        checkOutput("reset_ex_fields", {bus.ex_op_o, bus.ex_tag_o, bus.ex_rs1_o}, 64'd0);

        // Both operands valid: ex_valid one edge after the allocating edge.
        rst = 1'b1;
        bus.ex_ready_i = 1'b1;
        exp_q.push_back('{op: 6'h03, tag: 4'd5, rs1: 32'd10, rs2: 32'd20});
        tick();
        stopIssue();
        checkOutput("latency_not_early", 64'(bus.ex_valid_o), 64'd0);
        tick();
        checkOutput("latency_valid", 64'(bus.ex_valid_o), 64'd1);
        checkOutput("latency_tag", 64'(bus.ex_tag_o), 64'd5);
        tick();
        tick();

        // Wakeup of rs1 from the CDB two cycles after issue.
        applyStimulus(6'h04, 4'd1, 1'b0, 32'd0, 4'd3, 1'b1, 32'd7, 4'd0);
        tick();
        stopIssue();
        tick();
        checkOutput("wakeup_waiting", 64'(bus.ex_valid_o), 64'd0);
        setCdb(1'b1, 4'd3, 32'd16);
        exp_q.push_back('{op: 6'h04, tag: 4'd1, rs1: 32'd16, rs2: 32'd7});
        tick();
        setCdb(1'b0, 4'd0, 32'd0);
`ifdef RS_CDB_SELECT_BYPASS_EN
        checkOutput("wakeup_edge_w", 64'(bus.ex_valid_o), 64'd1);
        tick();
        checkOutput("wakeup_edge_w1", 64'(bus.ex_valid_o), 64'd0);
`else
        checkOutput("wakeup_edge_w", 64'(bus.ex_valid_o), 64'd0);
        tick();
        checkOutput("wakeup_edge_w1", 64'(bus.ex_valid_o), 64'd1);
`endif
        tick();
        tick();

        // Fill all entries pending on tag 9; the fifth issue is dropped.
        bus.ex_ready_i = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            applyStimulus(6'(6'h10 + t), 4'(t), 1'b0, 32'd0, 4'd9, 1'b1, 32'(32'h100 + t), 4'd0);
            tick();
        end
        checkOutput("full_flag", 64'(bus.full_o), 64'd1);
        checkOutput("full_count", 64'(bus.count_o), 64'd4);
        applyStimulus(6'h15, 4'd5, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        tick();
        stopIssue();
        checkOutput("drop_count", 64'(bus.count_o), 64'd4);
        for (int t = 1; t <= 4; t++) begin
            exp_q.push_back('{op: 6'(6'h10 + t), tag: 4'(t), rs1: 32'h99, rs2: 32'(32'h100 + t)});
        end
        setCdb(1'b1, 4'd9, 32'h99);
        tick();
        setCdb(1'b0, 4'd0, 32'd0);
        tick();

        // Backpressure: the oldest entry sits in the output register, frozen.
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_stable", {bus.ex_valid_o, bus.ex_op_o, bus.ex_tag_o, bus.ex_rs1_o, bus.count_o},
                        {1'b1, 6'h11, 4'd1, 32'h99, 3'd3});
            tick();
        end
        bus.ex_ready_i = 1'b1;
        tick();
        checkOutput("next_after_ready", {bus.ex_valid_o, bus.ex_tag_o}, {1'b1, 4'd2});
        tick();
        tick();
        tick();
        checkOutput("drained", {bus.ex_valid_o, bus.count_o}, 64'd0);

        // Stall while the CDB wakes the entry: no dispatch until stall drops.
        applyStimulus(6'h05, 4'd7, 1'b0, 32'd0, 4'd2, 1'b1, 32'd3, 4'd0);
        tick();
        stopIssue();
        bus.stall_i = 1'b1;
        setCdb(1'b1, 4'd2, 32'hAB);
        exp_q.push_back('{op: 6'h05, tag: 4'd7, rs1: 32'hAB, rs2: 32'd3});
        tick();
        setCdb(1'b0, 4'd0, 32'd0);
        checkOutput("stall_no_dispatch0", 64'(bus.ex_valid_o), 64'd0);
        tick();
        tick();
        checkOutput("stall_no_dispatch2", 64'(bus.ex_valid_o), 64'd0);
        bus.stall_i = 1'b0;
        tick();
        checkOutput("after_stall", {bus.ex_valid_o, bus.ex_rs1_o}, {1'b1, 32'hAB});

        // Issue-time bypass of a pending rs2.
        applyStimulus(6'h06, 4'd8, 1'b1, 32'd1, 4'd0, 1'b0, 32'd0, 4'd6);
        setCdb(1'b1, 4'd6, 32'h55);
        exp_q.push_back('{op: 6'h06, tag: 4'd8, rs1: 32'd1, rs2: 32'h55});
        tick();
        stopIssue();
        setCdb(1'b0, 4'd0, 32'd0);
        tick();
        checkOutput("issue_bypass", {bus.ex_valid_o, bus.ex_rs2_o}, {1'b1, 32'h55});
        tick();
        tick();

        // Flush with three busy entries and a held output.
        bus.ex_ready_i = 1'b0;
        for (int t = 10; t <= 12; t++) begin
            applyStimulus(6'h20, 4'(t), 1'b1, 32'(t), 4'd0, 1'b1, 32'd1, 4'd0);
            tick();
        end
        applyStimulus(6'h21, 4'd13, 1'b0, 32'd0, 4'd14, 1'b1, 32'd1, 4'd0);
        tick();
        stopIssue();
        checkOutput("pre_flush", {bus.ex_valid_o, bus.ex_tag_o, bus.count_o}, {1'b1, 4'd10, 3'd3});
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        checkOutput("post_flush", {bus.ex_valid_o, bus.full_o, bus.ex_op_o, bus.ex_tag_o, bus.ex_rs1_o, bus.count_o},
                    64'd0);
        bus.ex_ready_i = 1'b1;
        setCdb(1'b1, 4'd14, 32'h77);
        tick();
        setCdb(1'b0, 4'd0, 32'd0);
        tick();
        tick();
        checkOutput("flush_no_dispatch", {bus.ex_valid_o, bus.count_o}, 64'd0);
        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
